// File: rtl/spi_pkg.sv
// Shared types and command encodings for the SPI slave front-end.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_miso_serializer.sv
// Parallel-in/serial-out shifter driving MISO, MSB first, DATA_W bits per load.
module spi_miso_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              abort,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              done
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     remain;
  logic              busy;

  // Asserted on the edge that retires the last bit, so the caller can act on it in the same cycle.
  assign done = busy && (remain == '0) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      remain <= '0;
      busy   <= 1'b0;
      miso   <= 1'b0;
    end else if (abort) begin
      sreg   <= '0;
      remain <= '0;
      busy   <= 1'b0;
      miso   <= 1'b0;
    end else if (load) begin
      miso   <= data[DATA_W-1];
      sreg   <= {data[DATA_W-2:0], 1'b0};
      remain <= CW'(DATA_W - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (remain == '0) begin
        miso <= 1'b0;
        busy <= 1'b0;
      end else begin
        miso   <= sreg[DATA_W-1];
        sreg   <= sreg << 1;
        remain <= remain - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises MOSI frames for the RAM and serialises RAM read data onto MISO.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int                CNT_W    = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 1);

  spi_state_e         state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-2:0] shift;
  logic               frame_done;
  logic               rd_addr_seen;
  logic               wait_tx;
  logic               load;
  logic               tx_done;

  assign load = (state == READ_DATA) && wait_tx && tx_valid && !SS_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      frame_done   <= 1'b0;
      rd_addr_seen <= 1'b0;
      wait_tx      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        shift      <= '0;
        frame_done <= 1'b0;
        wait_tx    <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            if (MOSI != CMD_RD_ADDR[1]) state <= WRITE;
            else if (!rd_addr_seen)     state <= READ_ADD;
            else                        state <= READ_DATA;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!frame_done) begin
              if (bit_cnt == LAST_BIT) begin
                rx_data    <= {shift, MOSI};
                rx_valid   <= 1'b1;
                frame_done <= 1'b1;
                bit_cnt    <= '0;
                if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                if (state == READ_DATA) wait_tx      <= 1'b1;
              end else begin
                shift   <= {shift[FRAME_W-3:0], MOSI};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (wait_tx && tx_valid) begin
              wait_tx <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
      // An aborted read-back never raises tx_done, so the address stays armed for a retry.
      if (tx_done) rd_addr_seen <= 1'b0;
    end
  end

  spi_miso_serializer #(
    .DATA_W(DATA_W)
  ) u_miso_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .abort (SS_n),
    .data  (tx_data),
    .miso  (MISO),
    .done  (tx_done)
  );

endmodule
